// File: rtl/gpio_in.sv
// -----------------------------------------------------------------------------
// gpio_in -- 8-bit general purpose input block with edge capture and interrupt.
//
// Each pin goes through a two-flop synchronizer. The synchronized sample is
// optionally debounced. The result is the accepted pin level, LEVEL.
// A 0->1 change of LEVEL sets a sticky RISE bit and a 1->0 change sets a
// sticky FALL bit. Reading RISE or FALL returns the register and clears it on
// the same edge. If a new edge arrives on that same edge, the new edge wins.
// The interrupt is the OR of all edge bits enabled by MASK.
//
// Optional feature:
//   GPIO_IN_DEBOUNCE_EN  When defined, each pin has a debounce counter. A new
//                        synchronized level is accepted only after it has been
//                        sampled for DB_CYCLES consecutive cycles. When not
//                        defined, LEVEL is the synchronized sample delayed by
//                        one register, and no counters are built.
//
// Parameters:
//   DB_CYCLES  stable synchronized samples needed to accept a level (debounce)
//   CNT_W      debounce counter width; 2**CNT_W must exceed DB_CYCLES
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous, active-high reset
//   pins      [7:0] asynchronous external pin levels
//   io_sel    [1:0] register select: 0=LEVEL 1=RISE 2=FALL 3=MASK
//   io_rd_en  one-cycle read strobe for the register chosen by io_sel
//   io_wr_en  one-cycle write strobe; only MASK (io_sel=3) is writable
//   wr_data   [7:0] MASK write data
//   data_in   [31:0] registered read data; bits [31:8] are always 0
//   rd_valid  high for one cycle when data_in carries fresh read data
//   irq       registered level interrupt, |((RISE|FALL) & MASK)
//
// CPU handshake: io_rd_en and io_wr_en are single-cycle strobes with no
// back-pressure. A read sampled on edge N updates data_in and pulses rd_valid
// on that same edge N, so both are valid during cycle N+1. A read and a write
// of MASK on the same edge return the old MASK and store wr_data.
// -----------------------------------------------------------------------------
module gpio_in #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pins,
  input  logic [1:0]  io_sel,
  input  logic        io_rd_en,
  input  logic        io_wr_en,
  input  logic [7:0]  wr_data,
  output logic [31:0] data_in,
  output logic        rd_valid,
  output logic        irq
);

  localparam logic [1:0] SEL_LEVEL = 2'd0;
  localparam logic [1:0] SEL_RISE  = 2'd1;
  localparam logic [1:0] SEL_FALL  = 2'd2;
  localparam logic [1:0] SEL_MASK  = 2'd3;

  // The debounce counter must be able to hold DB_CYCLES-1 without wrapping.
  localparam bit CNT_W_OK = (2 ** CNT_W) > DB_CYCLES;

  // If the configuration is illegal, elaboration produces an empty marker
  // block. The block is named so that it stands out in the elaborated
  // hierarchy.
  if (!CNT_W_OK) begin : g_cnt_w_too_small_for_db_cycles
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;   // s[i]: the synchronized sample
  logic [7:0] level_q, level_d;
  logic [7:0] rise_q,  rise_d;
  logic [7:0] fall_q,  fall_d;
  logic [7:0] mask_q,  mask_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = pins;
    sync2_d = sync1_q;
  end

  // ---------------------------------------------------------------------------
  // Level acceptance
  // ---------------------------------------------------------------------------
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  // The counter measures how long s has differed from LEVEL. Any sample that
  // agrees with LEVEL restarts the count, so a glitch shorter than DB_CYCLES
  // never reaches DB_LAST. When the count reaches DB_LAST, the sample that
  // arrives on the next edge is the DB_CYCLES-th differing sample. On that
  // edge LEVEL takes s and the counter returns to 0. The counter is therefore
  // bounded by DB_LAST and never wraps.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  // No filtering. Every synchronized change is accepted one register later.
  always_comb begin
    level_d = sync2_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // Edge capture, mask, read path, interrupt
  // ---------------------------------------------------------------------------
  logic [7:0] rise_set, fall_set;
  logic [7:0] rise_clr, fall_clr;
  logic [7:0] rd_mux;

  always_comb begin
    rise_set = level_d & ~level_q;
    fall_set = ~level_d & level_q;

    rise_clr = (io_rd_en && io_sel == SEL_RISE) ? 8'hFF : 8'h00;
    fall_clr = (io_rd_en && io_sel == SEL_FALL) ? 8'hFF : 8'h00;

    // The set term is ORed in after the clear, so a new edge on the
    // read-to-clear edge stays set. The read data comes from rise_q/fall_q,
    // so it shows the value from before that edge.
    rise_d = (rise_q & ~rise_clr) | rise_set;
    fall_d = (fall_q & ~fall_clr) | fall_set;

    mask_d = (io_wr_en && io_sel == SEL_MASK) ? wr_data : mask_q;

    case (io_sel)
      SEL_LEVEL: rd_mux = level_q;
      SEL_RISE:  rd_mux = rise_q;
      SEL_FALL:  rd_mux = fall_q;
      default:   rd_mux = mask_q;
    endcase

    rd_data_d  = io_rd_en ? rd_mux : rd_data_q;
    rd_valid_d = io_rd_en;

    // irq uses next-state values. It therefore drops on the same edge that
    // clears or masks the last enabled bit.
    irq_d = |((rise_d | fall_d) & mask_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      mask_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      mask_q     <= mask_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign data_in  = {24'h000000, rd_data_q};
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_in.sv
// -----------------------------------------------------------------------------
// tb_gpio_in -- directed, self-checking bench for gpio_in.
// Expected values are hand-computed. LAT is the number of edges from a pin
// change (driven just after an edge) to the LEVEL update:
//   2 synchronizer edges + 1 register (no debounce), or
//   2 synchronizer edges + DB_CYCLES (debounce).
// -----------------------------------------------------------------------------
module tb_gpio_in;

  localparam int DB_CYCLES = 16;
  localparam int CNT_W     = 5;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int  LAT    = 2 + DB_CYCLES;
  localparam bit  DB_ON  = 1'b1;
`else
  localparam int  LAT    = 3;
  localparam bit  DB_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pins;
  logic [1:0]  io_sel;
  logic        io_rd_en;
  logic        io_wr_en;
  logic [7:0]  wr_data;
  logic [31:0] data_in;
  logic        rd_valid;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  gpio_in #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pins     (pins),
    .io_sel   (io_sel),
    .io_rd_en (io_rd_en),
    .io_wr_en (io_wr_en),
    .wr_data  (wr_data),
    .data_in  (data_in),
    .rd_valid (rd_valid),
    .irq      (irq)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Driver and checking tasks
  // ---------------------------------------------------------------------------
  // Advance to just after the next rising edge. Drive and sample from there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] sel, output logic [31:0] d);
    io_sel   = sel;
    io_rd_en = 1'b1;
    tick();
    io_rd_en = 1'b0;
    d = data_in;
    check("rd_valid_pulse", {31'd0, rd_valid}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] d);
    io_sel   = 2'd3;
    wr_data  = d;
    io_wr_en = 1'b1;
    tick();
    io_wr_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [31:0] d;

  initial begin
    rst      = 1'b1;
    pins     = 8'h00;
    io_sel   = 2'd0;
    io_rd_en = 1'b0;
    io_wr_en = 1'b0;
    wr_data  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("reset_data_in", data_in, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);

    // LEVEL read with pins low; rd_valid lasts one cycle
    do_read(2'd0, d);
    check("level_idle", d, 32'h0);
    tick();
    check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

    // MASK write/read; data_in holds while idle
    do_write(8'h01);
    do_read(2'd3, d);
    check("mask_rd_01", d, 32'h01);
    tick();
    check("data_in_hold", data_in, 32'h01);

    // pins[0] rises: irq appears exactly LAT edges later
    pins = 8'h01;
    repeat (LAT - 1) tick();
    check("irq_before_lat", {31'd0, irq}, 32'd0);
    tick();
    check("irq_at_lat", {31'd0, irq}, 32'd1);
    do_read(2'd0, d);
    check("level_bit0", d, 32'h01);
    do_read(2'd1, d);
    check("rise_bit0", d, 32'h01);
    check("irq_after_clear", {31'd0, irq}, 32'd0);
    do_read(2'd1, d);
    check("rise_cleared", d, 32'h0);
    do_read(2'd2, d);
    check("fall_none", d, 32'h0);

    // Write with io_sel != 3 is ignored
    io_sel = 2'd1; wr_data = 8'hFF; io_wr_en = 1'b1;
    tick();
    io_wr_en = 1'b0;
    do_read(2'd3, d);
    check("mask_unaffected", d, 32'h01);

    // One-cycle pulse on pins[2]
    pins = 8'h05;
    tick();
    pins = 8'h01;
    repeat (LAT + 2) tick();
    do_read(2'd1, d);
    check("pulse_rise", d, DB_ON ? 32'h0 : 32'h04);
    do_read(2'd2, d);
    check("pulse_fall", d, DB_ON ? 32'h0 : 32'h04);

    // 10-cycle glitch on pins[3]
    pins = 8'h09;
    repeat (10) tick();
    pins = 8'h01;
    repeat (LAT + 2) tick();
    do_read(2'd0, d);
    check("glitch_level", d, 32'h01);
    do_read(2'd1, d);
    check("glitch_rise", d, DB_ON ? 32'h0 : 32'h08);
    do_read(2'd2, d);
    check("glitch_fall", d, DB_ON ? 32'h0 : 32'h08);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // pins[5] edge lands on the RISE read-to-clear edge: set wins
    pins = 8'h21;
    repeat (LAT - 1) tick();
    io_sel   = 2'd1;
    io_rd_en = 1'b1;
    tick();
    io_rd_en = 1'b0;
    check("setwin_rd_data", data_in, 32'h0);
    do_read(2'd1, d);
    check("setwin_rise_kept", d, 32'h20);

    // Simultaneous read/write of MASK
    do_write(8'hA5);
    io_sel = 2'd3; wr_data = 8'h3C; io_wr_en = 1'b1; io_rd_en = 1'b1;
    tick();
    io_wr_en = 1'b0; io_rd_en = 1'b0;
    check("rdwr_old_mask", data_in, 32'hA5);
    do_read(2'd3, d);
    check("rdwr_new_mask", d, 32'h3C);

    // pins[0] falls while masked off; irq follows MASK writes
    pins = 8'h20;
    repeat (LAT + 1) tick();
    check("fall_masked_irq", {31'd0, irq}, 32'd0);
    do_write(8'h01);
    check("mask_on_irq", {31'd0, irq}, 32'd1);
    do_write(8'h00);
    check("mask_off_irq", {31'd0, irq}, 32'd0);

    // Reset with strobes active; pin held high comes back as LEVEL/RISE
    rst = 1'b1;
    io_sel = 2'd3; io_rd_en = 1'b1; io_wr_en = 1'b1; wr_data = 8'hFF;
    repeat (2) tick();
    check("rst_data_in", data_in, 32'h0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    io_rd_en = 1'b0; io_wr_en = 1'b0;
    rst = 1'b0;
    do_read(2'd3, d);
    check("rst_mask", d, 32'h0);
    repeat (LAT - 1) tick();
    do_read(2'd0, d);
    check("post_rst_level", d, 32'h20);
    do_read(2'd1, d);
    check("post_rst_rise", d, 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
